// File: rtl/aes_pkg.sv
// Shared types and constants for the AES feeder path: block/key widths,
// core latency, feeder FSM states and the buffered {key, data} request.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;
  localparam int AES_LAT   = 11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } feeder_state_e;

  typedef struct packed {
    logic [AES_KEY_W-1:0] key;
    logic [AES_BLK_W-1:0] data;
  } aes_req_t;

endpackage

// File: rtl/aes_req_fifo.sv
// Synchronous FIFO of aes_req_t with a combinational head, occupancy count
// and full/empty flags. DEPTH must be a power of two so the pointers wrap.
module aes_req_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          push,
  input  aes_req_t      push_req,
  input  logic          pop,
  output aes_req_t      head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  aes_req_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & !full;
  assign pop_ok  = pop & !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_req;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_feeder.sv
// Issue/collect stage around the iterative AES core: buffers requests, launches
// one block at a time into an idle core and parks the result in an output slot.
// Optional watchdog and protocol-error flag: define AES_FEEDER_WDOG_EN.
module aes_feeder
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int AES_LAT    = aes_pkg::AES_LAT
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 in_v_i,
  output logic                 in_ready_o,
  input  logic [AES_BLK_W-1:0] in_data_i,
  input  logic [AES_KEY_W-1:0] in_key_i,
  output logic                 aes_v_o,
  output logic [AES_BLK_W-1:0] aes_data_o,
  output logic [AES_KEY_W-1:0] aes_key_o,
  input  logic                 aes_res_v_i,
  input  logic [AES_BLK_W-1:0] aes_res_i,
  output logic                 out_v_o,
  input  logic                 out_ready_i,
  output logic [AES_BLK_W-1:0] out_data_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  aes_req_t      push_req;
  aes_req_t      head;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_count_unused;
  feeder_state_e state;
  logic          res_take;

  assign push_req = '{key: in_key_i, data: in_data_i};

  aes_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .nreset   (nreset),
    .push     (in_v_i),
    .push_req (push_req),
    .pop      (aes_v_o),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (fifo_count_unused)
  );

  assign in_ready_o = !full;
  assign aes_data_o = head.data;
  assign aes_key_o  = head.key;
  // Only launch when the slot is free or draining now, so a result never lands on a full slot.
  assign aes_v_o    = (state == IDLE) & !empty & (!out_v_o | out_ready_i);
  assign res_take   = (state == RUN) & aes_res_v_i;
  assign busy_o     = (state == RUN);

  always_ff @(posedge clk) begin
    if (!nreset) begin
      out_v_o    <= 1'b0;
      out_data_o <= '0;
    end else if (res_take) begin
      out_v_o    <= 1'b1;
      out_data_o <= aes_res_i;
    end else if (out_ready_i) begin
      out_v_o    <= 1'b0;
    end
  end

`ifdef AES_FEEDER_WDOG_EN
  localparam int CNT_W = $clog2(AES_LAT + 2);

  logic [CNT_W-1:0] cnt;
  logic             timeout;

  // Last cycle the core may answer; no result by then means it is wedged.
  assign timeout = (state == RUN) & !aes_res_v_i & (cnt == CNT_W'(AES_LAT));

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
      cnt   <= '0;
      err_o <= 1'b0;
    end else begin
      if (aes_v_o) begin
        state <= RUN;
        cnt   <= CNT_W'(1);
      end else if (res_take || timeout) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (state == RUN) begin
        cnt   <= cnt + CNT_W'(1);
      end
      if (timeout || ((state == IDLE) && aes_res_v_i)) err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
    end else if (aes_v_o) begin
      state <= RUN;
    end else if (res_take) begin
      state <= IDLE;
    end
  end
`endif

endmodule

// File: doc/aes_feeder.md
Name: aes_feeder

Overview:
- Upstream issue/collect stage for the iterative 11-cycle AES core (ports data_v_i/data_i/key_i, res_v_o/res_o).
- Buffers {plaintext, key} requests from a valid/ready source in a small FIFO.
- Launches a request into the core only when the core is idle.
- Captures the core result into a registered valid/ready output slot, so callers see clean backpressure on both sides.

Parameters:
- FIFO_DEPTH, 4, number of {data,key} entries buffered (power of two, >=2).
- AES_LAT, 11, cycles from launch (core data_v_i) to core res_v_o.

Ports:
- clk  in  1  clock
- nreset  in  1  synchronous active-low reset
- in_v_i  in  1  request valid
- in_ready_o  out  1  request accepted when in_v_i & in_ready_o
- in_data_i  in  128  plaintext block
- in_key_i  in  128  cipher key
- aes_v_o  out  1  launch pulse to core data_v_i
- aes_data_o  out  128  to core data_i
- aes_key_o  out  128  to core key_i
- aes_res_v_i  in  1  from core res_v_o
- aes_res_i  in  128  from core res_o
- out_v_o  out  1  ciphertext valid
- out_ready_i  in  1  consumer ready
- out_data_o  out  128  ciphertext
- busy_o  out  1  core has a block in flight
- err_o  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset is on nreset, synchronous, active-low; clock is clk.
- Reset values: FIFO empty, in_ready_o=1 from the first cycle after reset, aes_v_o=0, out_v_o=0, out_data_o=0, busy_o=0, err_o=0, state=IDLE, cnt=0.
- Reset mid-operation discards the FIFO contents, the in-flight block and the output slot. The core shares nreset.

FIFO:
- Write pointer, read pointer and occupancy count; the count is $clog2(FIFO_DEPTH+1) bits wide.
- Pointers wrap modulo FIFO_DEPTH.
- in_ready_o = !full. There is no pass-through when full, even if a pop happens in the same cycle.
- Push and pop in the same cycle leave the count unchanged.
- No bypass when empty: a request written at cycle t is launched at t+1 at the earliest.

Launch:
- aes_data_o and aes_key_o are driven combinationally from the FIFO head and are stable while aes_v_o=1.
- aes_v_o = (state==IDLE) & !empty & (!out_v_o | out_ready_i). The pop occurs in the same cycle.
- aes_v_o is a single-cycle pulse and is never asserted in RUN.

State machine:
- IDLE -> RUN on launch; cnt is set to 1.
- RUN: cnt increments each cycle.
  - On aes_res_v_i: out_data_o <= aes_res_i, out_v_o <= 1, go to IDLE.
  - The earliest next launch is the cycle after the result. The core finish cycle must not be overlapped.
- busy_o = (state==RUN).

Output slot:
- out_v_o clears on out_ready_i unless it is refilled in the same cycle.
- A result cannot arrive while the slot is full, by the launch rule.

Timing:
- Latency from launch to out_v_o is AES_LAT+1 = 12 cycles.
- Maximum throughput is one block per 12 cycles.

Optional Feature:
- Macro AES_FEEDER_WDOG_EN.
- With the macro:
  - err_o sets and stays set until reset if cnt reaches AES_LAT+1 without aes_res_v_i. The FSM then returns to IDLE, discarding the block.
  - err_o also sets on aes_res_v_i while in IDLE; that result is dropped.
- Without the macro:
  - err_o is tied 0 and cnt is omitted.
  - RUN waits indefinitely for aes_res_v_i.
  - aes_res_v_i in IDLE is ignored.

Decomposition:
- Shared package aes_pkg holds:
  - AES_BLK_W=128 and AES_KEY_W=128.
  - AES_LAT=11.
  - The feeder state enum {IDLE, RUN}.
  - A packed struct aes_req_t {key, data} (256 bits) used as the FIFO entry.
- One sub-module, aes_req_fifo: synchronous FIFO of aes_req_t with full/empty/count outputs.
- The feeder FSM and the output slot stay in aes_feeder.

Test Plan:
- FIPS-197 single block: data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, pushed at cycle 0, out_ready_i=1 -> aes_v_o pulses at cycle 1; out_v_o at cycle 13 with 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back: 6 requests pushed on consecutive cycles -> in_ready_o drops after the 5th push (4 buffered + 1 launched); launches 12 cycles apart; results in order.
- Output backpressure: out_ready_i=0 for 40 cycles with 3 queued requests -> exactly one result is held stable and no second launch occurs; releasing out_ready_i launches the next block in the same cycle as the pop.
- Full with simultaneous pop: FIFO full, launch occurs while in_v_i=1 -> push rejected that cycle; count goes from 4 to 3.
- Mid-flight reset: nreset low at launch+5 -> all outputs at reset values next cycle; no stale out_v_o afterwards.
- With AES_FEEDER_WDOG_EN: suppress aes_res_v_i -> err_o=1 at launch+12 and state returns to IDLE. Spurious aes_res_v_i in IDLE -> err_o=1 and out_v_o stays 0.
